// File: rtl/gtf_link_bringup_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gtf_bringup_pkg
// Shared definitions for the GTF raw-mode link bring-up sequencer:
//   - state_t    : FSM state encodings (visible on state_out)
//   - MAX_NUM_CHANNEL : upper bound on the number of GTF channels
//   - cnt_width  : width needed for a counter that counts 0..cycles-1
//   - max_int    : helper for combining counter widths
// -----------------------------------------------------------------------------
package gtf_bringup_pkg;

    localparam int MAX_NUM_CHANNEL = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_ALL   = 3'd1,
        ST_WAIT_PLL  = 3'd2,
        ST_DP_RST    = 3'd3,
        ST_WAIT_LINK = 3'd4,
        ST_CLR_LATCH = 3'd5,
        ST_RUN       = 3'd6,
        ST_FAIL      = 3'd7
    } state_t;

    // Counters compare against (cycles-1), so $clog2(cycles) bits suffice.
    function automatic int cnt_width(input int cycles);
        if (cycles <= 2) begin
            return 1;
        end else begin
            return $clog2(cycles);
        end
    endfunction

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/gtf_link_bringup_ctrl_sync2.sv
// -----------------------------------------------------------------------------
// gtf_bringup_sync2
// Parameterized-width two-flop synchronizer, reset to all zeros.
// Ports:
//   i_clk  : destination clock
//   i_rst  : asynchronous active-high reset
//   i_d    : asynchronous input vector
//   o_q    : synchronized output vector (2-cycle latency)
// -----------------------------------------------------------------------------
module gtf_bringup_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous inputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gtf_link_bringup_ctrl.sv
// -----------------------------------------------------------------------------
// gtf_link_bringup_ctrl
// Reset/bring-up sequencer for the GTF raw-mode example datapath. Drives the
// master and per-channel datapath resets, waits for QPLL lock and reset-done,
// qualifies the PRBS link over a stable window, clears the latched link-down
// indicators and then monitors the link, restarting or failing on error.
//
// Optional feature macro: GTF_BRINGUP_AUTO_RETRY_EN
//   defined   : errors re-run the bring-up up to MAX_RETRY times before FAIL
//   undefined : errors go straight to FAIL, retry_cnt_out stays 0
//
// Ports:
//   hb_gtwiz_reset_clk_freerun_in : free-running clock (only clock)
//   hb_gtwiz_reset_all_in         : async active-high reset
//   start_in                      : level, starts bring-up from IDLE/FAIL
//   gtf_cm_qpll0_lock_in          : QPLL0 lock (async)
//   gtwiz_reset_tx_done_in[N]     : TX reset done (async)
//   gtwiz_reset_rx_done_in[N]     : RX reset done (async)
//   link_status_in[N]             : PRBS link status (async)
//   link_down_latched_in[N]       : latched link-down (async)
//   gtwiz_reset_all_out           : master reset
//   gtf_ch_txdp_reset_out[N]      : TX datapath resets
//   gtf_ch_rxdp_reset_out[N]      : RX datapath resets
//   link_down_latched_reset_out[N]: clear pulse for the latched indicators
//   link_stable_out[N]            : per-channel stable flag
//   state_out[3]                  : FSM state encoding
//   retry_cnt_out[3]              : saturating retry count
//   link_up_out                   : high in RUN
//   fail_out                      : high in FAIL
// -----------------------------------------------------------------------------
module gtf_link_bringup_ctrl
    import gtf_bringup_pkg::*;
#(
    parameter int NUM_CHANNEL       = 1,
    parameter int RESET_HOLD_CYCLES = 1000,
    parameter int STABLE_CYCLES     = 2048,
    parameter int TIMEOUT_CYCLES    = 1048576,
    parameter int MAX_RETRY         = 3,
    parameter int LATCH_CLR_CYCLES  = 5
) (
    input  logic                   hb_gtwiz_reset_clk_freerun_in,
    input  logic                   hb_gtwiz_reset_all_in,
    input  logic                   start_in,
    input  logic                   gtf_cm_qpll0_lock_in,
    input  logic [NUM_CHANNEL-1:0] gtwiz_reset_tx_done_in,
    input  logic [NUM_CHANNEL-1:0] gtwiz_reset_rx_done_in,
    input  logic [NUM_CHANNEL-1:0] link_status_in,
    input  logic [NUM_CHANNEL-1:0] link_down_latched_in,
    output logic                   gtwiz_reset_all_out,
    output logic [NUM_CHANNEL-1:0] gtf_ch_txdp_reset_out,
    output logic [NUM_CHANNEL-1:0] gtf_ch_rxdp_reset_out,
    output logic [NUM_CHANNEL-1:0] link_down_latched_reset_out,
    output logic [NUM_CHANNEL-1:0] link_stable_out,
    output logic [2:0]             state_out,
    output logic [2:0]             retry_cnt_out,
    output logic                   link_up_out,
    output logic                   fail_out
);

`ifdef GTF_BRINGUP_AUTO_RETRY_EN
    localparam logic AUTO_RETRY = 1'b1;
`else
    localparam logic AUTO_RETRY = 1'b0;
`endif

    // The latched link-down input lags the clear pulse by the output register
    // plus the 2-flop synchronizer, so a stale value can linger for this many
    // cycles after entering RUN and is ignored during that time.
    localparam int LDL_GUARD = 3;

    localparam int CNT_W  = max_int(max_int(cnt_width(RESET_HOLD_CYCLES), cnt_width(TIMEOUT_CYCLES)),
                                    max_int(cnt_width(LATCH_CLR_CYCLES), cnt_width(LDL_GUARD + 1)));
    localparam int SCNT_W = cnt_width(STABLE_CYCLES);
    localparam int SYNC_W = 1 + 4 * NUM_CHANNEL;

    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CLR_LAST    = CNT_W'(LATCH_CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GUARD_C     = CNT_W'(LDL_GUARD);
    localparam logic [SCNT_W-1:0] STABLE_LAST = SCNT_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]        MAX_RETRY_C = (MAX_RETRY > 7) ? 3'd7 : 3'(MAX_RETRY);

    logic [SYNC_W-1:0]      w_async;
    logic [SYNC_W-1:0]      w_sync;
    logic                   w_pll_lock;
    logic [NUM_CHANNEL-1:0] w_tx_done;
    logic [NUM_CHANNEL-1:0] w_rx_done;
    logic [NUM_CHANNEL-1:0] w_link;
    logic [NUM_CHANNEL-1:0] w_ldl;
    logic                   w_pll_ok;
    logic                   w_run_err;

    state_t                 r_state;
    state_t                 w_state_nxt;
    state_t                 w_err_state;
    logic [2:0]             r_retry;
    logic [2:0]             w_retry_nxt;
    logic [2:0]             w_err_retry;
    logic [CNT_W-1:0]       r_cnt;
    logic [SCNT_W-1:0]      r_scnt [NUM_CHANNEL];
    logic [NUM_CHANNEL-1:0] r_stable;

    logic                   w_rst_all_d;
    logic                   w_dp_rst_d;
    logic                   w_clr_d;
    logic                   w_up_d;
    logic                   w_fail_d;
    logic                   r_rst_all_o;
    logic                   r_dp_rst_o;
    logic                   r_clr_o;
    logic                   r_up_o;
    logic                   r_fail_o;
    logic [2:0]             r_state_o;

    assign w_async = {gtf_cm_qpll0_lock_in, gtwiz_reset_tx_done_in, gtwiz_reset_rx_done_in,
                      link_status_in, link_down_latched_in};

    gtf_bringup_sync2 #(
        .WIDTH (SYNC_W)
    ) u_sync (
        .i_clk (hb_gtwiz_reset_clk_freerun_in),
        .i_rst (hb_gtwiz_reset_all_in),
        .i_d   (w_async),
        .o_q   (w_sync)
    );

    assign w_pll_lock = w_sync[SYNC_W-1];
    assign w_tx_done  = w_sync[4*NUM_CHANNEL-1:3*NUM_CHANNEL];
    assign w_rx_done  = w_sync[3*NUM_CHANNEL-1:2*NUM_CHANNEL];
    assign w_link     = w_sync[2*NUM_CHANNEL-1:NUM_CHANNEL];
    assign w_ldl      = w_sync[NUM_CHANNEL-1:0];

    assign w_pll_ok  = w_pll_lock & (&w_tx_done) & (&w_rx_done);
    assign w_run_err = (~&w_link) | ((r_cnt >= GUARD_C) & (|w_ldl));

    // Error-path destination: retry while budget remains, otherwise FAIL.
    always_comb begin
        w_err_state = ST_FAIL;
        w_err_retry = r_retry;
        if (AUTO_RETRY && (r_retry < MAX_RETRY_C)) begin
            w_err_state = ST_RST_ALL;
            w_err_retry = r_retry + 3'd1;
        end else begin
            w_err_state = ST_FAIL;
            w_err_retry = r_retry;
        end
    end

    // Next-state logic; success is tested before timeout so it wins a tie.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        case (r_state)
            ST_IDLE, ST_FAIL: begin
                if (start_in) begin
                    w_state_nxt = ST_RST_ALL;
                    w_retry_nxt = 3'd0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RST_ALL: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_WAIT_PLL;
                end else begin
                    w_state_nxt = ST_RST_ALL;
                end
            end
            ST_WAIT_PLL: begin
                if (w_pll_ok) begin
                    w_state_nxt = ST_DP_RST;
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = w_err_state;
                    w_retry_nxt = w_err_retry;
                end else begin
                    w_state_nxt = ST_WAIT_PLL;
                end
            end
            ST_DP_RST: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_WAIT_LINK;
                end else begin
                    w_state_nxt = ST_DP_RST;
                end
            end
            ST_WAIT_LINK: begin
                if (&r_stable) begin
                    w_state_nxt = ST_CLR_LATCH;
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = w_err_state;
                    w_retry_nxt = w_err_retry;
                end else begin
                    w_state_nxt = ST_WAIT_LINK;
                end
            end
            ST_CLR_LATCH: begin
                if (r_cnt == CLR_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_CLR_LATCH;
                end
            end
            ST_RUN: begin
                if (w_run_err) begin
                    w_state_nxt = w_err_state;
                    w_retry_nxt = w_err_retry;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, retry count and the shared hold/timeout counter (cleared on every
    // state change, saturating so the RUN guard never wraps).
    always_ff @(posedge hb_gtwiz_reset_clk_freerun_in or posedge hb_gtwiz_reset_all_in) begin
        if (hb_gtwiz_reset_all_in) begin
            r_state <= ST_IDLE;
            r_retry <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_retry <= w_retry_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Per-channel stable qualification; flags survive into CLR_LATCH/RUN and
    // drop on any low status there, and are cleared in every other state.
    always_ff @(posedge hb_gtwiz_reset_clk_freerun_in or posedge hb_gtwiz_reset_all_in) begin
        if (hb_gtwiz_reset_all_in) begin
            r_stable <= '0;
            for (int i = 0; i < NUM_CHANNEL; i++) begin
                r_scnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNEL; i++) begin
                case (r_state)
                    ST_WAIT_LINK: begin
                        if (!w_link[i]) begin
                            r_scnt[i]   <= '0;
                            r_stable[i] <= 1'b0;
                        end else if (r_scnt[i] == STABLE_LAST) begin
                            r_stable[i] <= 1'b1;
                        end else begin
                            r_scnt[i] <= r_scnt[i] + SCNT_W'(1);
                        end
                    end
                    ST_CLR_LATCH, ST_RUN: begin
                        r_scnt[i] <= '0;
                        if (!w_link[i]) begin
                            r_stable[i] <= 1'b0;
                        end
                    end
                    default: begin
                        r_scnt[i]   <= '0;
                        r_stable[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output decode from the current state.
    always_comb begin
        w_rst_all_d = 1'b0;
        w_dp_rst_d  = 1'b0;
        w_clr_d     = 1'b0;
        w_up_d      = 1'b0;
        w_fail_d    = 1'b0;
        case (r_state)
            ST_IDLE:      begin w_rst_all_d = 1'b1; w_dp_rst_d = 1'b1; end
            ST_RST_ALL:   begin w_rst_all_d = 1'b1; w_dp_rst_d = 1'b1; end
            ST_WAIT_PLL:  begin w_dp_rst_d  = 1'b1; end
            ST_DP_RST:    begin w_dp_rst_d  = 1'b1; end
            ST_WAIT_LINK: begin w_up_d      = 1'b0; end
            ST_CLR_LATCH: begin w_clr_d     = 1'b1; end
            ST_RUN:       begin w_up_d      = 1'b1; end
            ST_FAIL:      begin w_rst_all_d = 1'b1; w_dp_rst_d = 1'b1; w_fail_d = 1'b1; end
            default:      begin w_rst_all_d = 1'b1; w_dp_rst_d = 1'b1; end
        endcase
    end

    // Registered outputs; they follow the state one cycle later.
    always_ff @(posedge hb_gtwiz_reset_clk_freerun_in or posedge hb_gtwiz_reset_all_in) begin
        if (hb_gtwiz_reset_all_in) begin
            r_rst_all_o <= 1'b1;
            r_dp_rst_o  <= 1'b1;
            r_clr_o     <= 1'b0;
            r_up_o      <= 1'b0;
            r_fail_o    <= 1'b0;
            r_state_o   <= 3'd0;
        end else begin
            r_rst_all_o <= w_rst_all_d;
            r_dp_rst_o  <= w_dp_rst_d;
            r_clr_o     <= w_clr_d;
            r_up_o      <= w_up_d;
            r_fail_o    <= w_fail_d;
            r_state_o   <= r_state;
        end
    end

    assign gtwiz_reset_all_out         = r_rst_all_o;
    assign gtf_ch_txdp_reset_out       = {NUM_CHANNEL{r_dp_rst_o}};
    assign gtf_ch_rxdp_reset_out       = {NUM_CHANNEL{r_dp_rst_o}};
    assign link_down_latched_reset_out = {NUM_CHANNEL{r_clr_o}};
    assign link_stable_out             = r_stable;
    assign state_out                   = r_state_o;
    assign retry_cnt_out               = r_retry;
    assign link_up_out                 = r_up_o;
    assign fail_out                    = r_fail_o;

endmodule

// File: tb/tb_gtf_link_bringup_ctrl.sv
module tb_gtf_link_bringup_ctrl;

    localparam int NCH    = 4;
    localparam int HOLD   = 10;
    localparam int STABLE = 32;
    localparam int TMO    = 300;
    localparam int CLRW   = 5;

`ifdef GTF_BRINGUP_AUTO_RETRY_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           pll;
    logic [NCH-1:0] tx_done, rx_done, link, ldl;
    logic           rst_all_o;
    logic [NCH-1:0] txdp_o, rxdp_o, clr_o, stable_o;
    logic [2:0]     state_o, retry_o;
    logic           up_o, fail_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gtf_link_bringup_ctrl #(
        .NUM_CHANNEL       (NCH),
        .RESET_HOLD_CYCLES (HOLD),
        .STABLE_CYCLES     (STABLE),
        .TIMEOUT_CYCLES    (TMO),
        .MAX_RETRY         (3),
        .LATCH_CLR_CYCLES  (CLRW)
    ) dut (
        .hb_gtwiz_reset_clk_freerun_in (clk),
        .hb_gtwiz_reset_all_in         (rst),
        .start_in                      (start),
        .gtf_cm_qpll0_lock_in          (pll),
        .gtwiz_reset_tx_done_in        (tx_done),
        .gtwiz_reset_rx_done_in        (rx_done),
        .link_status_in                (link),
        .link_down_latched_in          (ldl),
        .gtwiz_reset_all_out           (rst_all_o),
        .gtf_ch_txdp_reset_out         (txdp_o),
        .gtf_ch_rxdp_reset_out         (rxdp_o),
        .link_down_latched_reset_out   (clr_o),
        .link_stable_out               (stable_o),
        .state_out                     (state_o),
        .retry_cnt_out                 (retry_o),
        .link_up_out                   (up_o),
        .fail_out                      (fail_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; pll = 1'b0;
        tx_done = '0; rx_done = '0; link = '0; ldl = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for a state; an expired bound counts as a failure.
    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n;
        n = 0;
        while (state_o !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (state_o !== st) begin
            n_fail++;
            $display("FAIL %s: state_out=%0d required %0d within %0d cycles", tag, state_o, st, budget);
        end
    endtask

    task automatic count_while(input logic [2:0] st, input int budget, output int cycles);
        cycles = 0;
        while (state_o === st && cycles < budget) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pll = 1'b0;
        tx_done = '0; rx_done = '0; link = '0; ldl = '0;
        repeat (2) @(negedge clk);
        n_tests += 9;
        if (state_o !== 3'd0)   begin n_fail++; $display("FAIL rst_state: got %0d required 0", state_o); end
        if (rst_all_o !== 1'b1) begin n_fail++; $display("FAIL rst_all: got %0b required 1", rst_all_o); end
        if (txdp_o !== 4'hF)    begin n_fail++; $display("FAIL rst_txdp: got %0h required f", txdp_o); end
        if (rxdp_o !== 4'hF)    begin n_fail++; $display("FAIL rst_rxdp: got %0h required f", rxdp_o); end
        if (clr_o !== 4'h0)     begin n_fail++; $display("FAIL rst_clr: got %0h required 0", clr_o); end
        if (stable_o !== 4'h0)  begin n_fail++; $display("FAIL rst_stable: got %0h required 0", stable_o); end
        if (retry_o !== 3'd0)   begin n_fail++; $display("FAIL rst_retry: got %0d required 0", retry_o); end
        if (up_o !== 1'b0)      begin n_fail++; $display("FAIL rst_up: got %0b required 0", up_o); end
        if (fail_o !== 1'b0)    begin n_fail++; $display("FAIL rst_fail: got %0b required 0", fail_o); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_tests += 2;
        if (state_o !== 3'd0)   begin n_fail++; $display("FAIL idle_hold: state %0d required 0", state_o); end
        if (rst_all_o !== 1'b1) begin n_fail++; $display("FAIL idle_rst_all: got %0b required 1", rst_all_o); end
    endtask

    task automatic test_nominal();
        int c;
        do_reset();
        pulse_start();
        wait_state(3'd1, 10, "nom_enter_rst_all");
        count_while(3'd1, 100, c);
        n_tests += 2;
        if (c !== HOLD)       begin n_fail++; $display("FAIL nom_rst_all_len: got %0d required %0d", c, HOLD); end
        if (state_o !== 3'd2) begin n_fail++; $display("FAIL nom_wait_pll: state %0d required 2", state_o); end
        repeat (100) @(negedge clk);
        n_tests++;
        if (state_o !== 3'd2) begin n_fail++; $display("FAIL nom_pll_wait_hold: state %0d required 2", state_o); end
        pll = 1'b1; tx_done = 4'hF; rx_done = 4'hF;
        c = 0;
        while (state_o !== 3'd3 && c < 20) begin @(negedge clk); c++; end
        n_tests += 2;
        if (c !== 4)        begin n_fail++; $display("FAIL nom_pll_latency: got %0d required 4", c); end
        if (txdp_o !== 4'hF) begin n_fail++; $display("FAIL nom_dp_rst_on: got %0h required f", txdp_o); end
        count_while(3'd3, 100, c);
        n_tests += 4;
        if (c !== HOLD)       begin n_fail++; $display("FAIL nom_dp_rst_len: got %0d required %0d", c, HOLD); end
        if (state_o !== 3'd4) begin n_fail++; $display("FAIL nom_wait_link: state %0d required 4", state_o); end
        if (txdp_o !== 4'h0)  begin n_fail++; $display("FAIL nom_txdp_off: got %0h required 0", txdp_o); end
        if (rxdp_o !== 4'h0)  begin n_fail++; $display("FAIL nom_rxdp_off: got %0h required 0", rxdp_o); end
        repeat (50) @(negedge clk);
        link = 4'hF;
        c = 0;
        while (stable_o !== 4'hF && c < 200) begin @(negedge clk); c++; end
        n_tests++;
        if (c !== STABLE + 2) begin n_fail++; $display("FAIL nom_stable_latency: got %0d required %0d", c, STABLE + 2); end
        wait_state(3'd5, 10, "nom_enter_clr");
        c = 0;
        while (clr_o === 4'hF && c < 20) begin c++; @(negedge clk); end
        n_tests += 4;
        if (c !== CLRW)       begin n_fail++; $display("FAIL nom_clr_pulse: got %0d required %0d", c, CLRW); end
        if (state_o !== 3'd6) begin n_fail++; $display("FAIL nom_run: state %0d required 6", state_o); end
        if (up_o !== 1'b1)    begin n_fail++; $display("FAIL nom_link_up: got %0b required 1", up_o); end
        if (rst_all_o !== 1'b0) begin n_fail++; $display("FAIL nom_rst_all_off: got %0b required 0", rst_all_o); end
        // latched link-down well after the clear window takes the error path
        repeat (10) @(negedge clk);
        ldl = 4'b0001;
        repeat (3) @(negedge clk);
        n_tests++;
        if (state_o !== 3'd6) begin n_fail++; $display("FAIL nom_ldl_early: state %0d required 6", state_o); end
        @(negedge clk);
        n_tests++;
        if (state_o !== (AUTO ? 3'd1 : 3'd7)) begin
            n_fail++; $display("FAIL nom_ldl_err: state %0d required %0d", state_o, AUTO ? 1 : 7);
        end
        ldl = '0;
    endtask

    task automatic test_link_glitch();
        int c;
        do_reset();
        pulse_start();
        pll = 1'b1; tx_done = 4'hF; rx_done = 4'hF;
        wait_state(3'd4, 200, "gl_enter_wait_link");
        link = 4'hF;
        repeat (20) @(negedge clk);
        n_tests++;
        if (stable_o !== 4'h0) begin n_fail++; $display("FAIL gl_not_yet: got %0h required 0", stable_o); end
        link = 4'h0;
        @(negedge clk);
        link = 4'hF;
        c = 0;
        while (stable_o !== 4'hF && c < 200) begin @(negedge clk); c++; end
        n_tests++;
        if (c !== STABLE + 2) begin n_fail++; $display("FAIL gl_restart: got %0d required %0d", c, STABLE + 2); end
    endtask

    task automatic test_run_loss();
        wait_state(3'd6, 50, "loss_enter_run");
        repeat (10) @(negedge clk);
        link = 4'b1011;
        repeat (3) @(negedge clk);
        n_tests += 2;
        if (stable_o !== 4'b1011) begin n_fail++; $display("FAIL loss_stable2: got %0h required b", stable_o); end
        if (state_o !== 3'd6)     begin n_fail++; $display("FAIL loss_state_lag: state %0d required 6", state_o); end
        @(negedge clk);
        n_tests += 4;
        if (state_o !== (AUTO ? 3'd1 : 3'd7)) begin
            n_fail++; $display("FAIL loss_err_state: state %0d required %0d", state_o, AUTO ? 1 : 7);
        end
        if (stable_o !== 4'h0) begin n_fail++; $display("FAIL loss_flags_clr: got %0h required 0", stable_o); end
        if (retry_o !== (AUTO ? 3'd1 : 3'd0)) begin
            n_fail++; $display("FAIL loss_retry: got %0d required %0d", retry_o, AUTO ? 1 : 0);
        end
        if (fail_o !== (AUTO ? 1'b0 : 1'b1)) begin
            n_fail++; $display("FAIL loss_fail: got %0b required %0b", fail_o, !AUTO);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_start();
        pll = 1'b1; tx_done = 4'hF; rx_done = 4'hF;
        wait_state(3'd3, 100, "ar_enter_dp_rst");
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests += 5;
        if (state_o !== 3'd0)   begin n_fail++; $display("FAIL ar_state: got %0d required 0", state_o); end
        if (rst_all_o !== 1'b1) begin n_fail++; $display("FAIL ar_rst_all: got %0b required 1", rst_all_o); end
        if (txdp_o !== 4'hF)    begin n_fail++; $display("FAIL ar_txdp: got %0h required f", txdp_o); end
        if (rxdp_o !== 4'hF)    begin n_fail++; $display("FAIL ar_rxdp: got %0h required f", rxdp_o); end
        if (clr_o !== 4'h0)     begin n_fail++; $display("FAIL ar_clr: got %0h required 0", clr_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timeout_retry();
        int c;
        int entries;
        int guard;
        logic [2:0] prev;
        do_reset();
        pulse_start();
        wait_state(3'd1, 10, "to_enter_rst_all");
        entries = 1;
        count_while(3'd1, 100, c);
        count_while(3'd2, 1000, c);
        n_tests++;
        if (c !== TMO) begin n_fail++; $display("FAIL to_wait_pll_len: got %0d required %0d", c, TMO); end
        if (state_o === 3'd1) entries++;
        prev = state_o;
        guard = 0;
        while (fail_o !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (state_o === 3'd1 && prev !== 3'd1) entries++;
            prev = state_o;
        end
        n_tests += 4;
        if (fail_o !== 1'b1)  begin n_fail++; $display("FAIL to_fail_out: got %0b required 1", fail_o); end
        if (state_o !== 3'd7) begin n_fail++; $display("FAIL to_state: got %0d required 7", state_o); end
        if (entries !== (AUTO ? 4 : 1)) begin
            n_fail++; $display("FAIL to_entries: got %0d required %0d", entries, AUTO ? 4 : 1);
        end
        if (retry_o !== (AUTO ? 3'd3 : 3'd0)) begin
            n_fail++; $display("FAIL to_retry: got %0d required %0d", retry_o, AUTO ? 3 : 0);
        end
    endtask

    task automatic test_restart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (retry_o !== 3'd0) begin n_fail++; $display("FAIL rs_retry: got %0d required 0", retry_o); end
        @(negedge clk);
        n_tests += 2;
        if (state_o !== 3'd1) begin n_fail++; $display("FAIL rs_state: got %0d required 1", state_o); end
        if (fail_o !== 1'b0)  begin n_fail++; $display("FAIL rs_fail: got %0b required 0", fail_o); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_link_glitch();
        test_run_loss();
        test_async_reset();
        test_timeout_retry();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
